// File: rtl/excp_flush_ctrl_if.sv
// Exception / flush controller bundle.
// Groups the WB-stage event inputs, the CSR-file inputs, the IF redirect
// handshake and every controller output into one interface.
//   slave  : the controller side (excp_flush_ctrl)
//   master : the pipeline / CSR-file side that drives the events
interface excp_flush_ctrl_if;
  // WB-stage event
  logic        wb_valid;
  logic        wb_ex;
  logic        wb_ertn;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  // CSR write request from the WB instruction
  logic        csr_we_req;
  logic [13:0] csr_num_i;
  logic [31:0] csr_wmask_i;
  logic [31:0] csr_wvalue_i;
  // CSR file status
  logic        int_pending;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  // IF handshake
  logic        fetch_ready;
  // Gated CSR write port
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  // Commit pulses and cause
  logic        exc_commit;
  logic [5:0]  exc_ecode;
  logic [8:0]  exc_esubcode;
  logic [31:0] exc_pc;
  logic        ertn_commit;
  // Pipeline control
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ws_stall;

  modport slave (
    input  wb_valid, wb_ex, wb_ertn, wb_ecode, wb_esubcode, wb_pc,
    input  csr_we_req, csr_num_i, csr_wmask_i, csr_wvalue_i,
    input  int_pending, csr_eentry, csr_era, fetch_ready,
    output csr_we, csr_num, csr_wmask, csr_wvalue,
    output exc_commit, exc_ecode, exc_esubcode, exc_pc, ertn_commit,
    output flush, redirect_valid, redirect_pc, ws_stall
  );

  modport master (
    output wb_valid, wb_ex, wb_ertn, wb_ecode, wb_esubcode, wb_pc,
    output csr_we_req, csr_num_i, csr_wmask_i, csr_wvalue_i,
    output int_pending, csr_eentry, csr_era, fetch_ready,
    input  csr_we, csr_num, csr_wmask, csr_wvalue,
    input  exc_commit, exc_ecode, exc_esubcode, exc_pc, ertn_commit,
    input  flush, redirect_valid, redirect_pc, ws_stall
  );
endinterface

// File: rtl/excp_flush_ctrl.sv
// Exception / interrupt / ERTN commit and pipeline flush controller.
// Commits at most one WB event while idle (interrupt > exception > ERTN,
// CSR write may accompany an ERTN), then holds flush for FLUSH_CYCLES+1
// cycles in total and presents the latched target PC to IF until it is
// accepted. WB is stalled for the whole sequence.
// Ports:
//   clk    - sole clock, rising edge
//   resetn - synchronous active-low reset; all outputs forced low while low
//   bus    - excp_flush_ctrl_if.slave: WB events, CSR status, IF handshake,
//            gated CSR write port, commit pulses, flush/redirect/stall
module excp_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  ECODE_INT    = 6'h00
) (
  input logic              clk,
  input logic              resetn,
  excp_flush_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic idle;
  logic take_int;
  logic take_ex;
  logic take_ertn;
  logic take_csr;
  logic exc_take;

  // Folding resetn into idle gates every commit/write output during reset.
  assign idle      = resetn && (state_q == IDLE);
  assign take_int  = idle && bus.wb_valid && bus.int_pending;
  assign take_ex   = idle && bus.wb_valid && bus.wb_ex && !bus.int_pending;
  assign take_ertn = idle && bus.wb_valid && bus.wb_ertn && !bus.wb_ex && !bus.int_pending;
  assign take_csr  = idle && bus.wb_valid && bus.csr_we_req && !bus.wb_ex && !bus.int_pending;
  assign exc_take  = take_int || take_ex;

  // Gated CSR write port
  assign bus.csr_we     = take_csr;
  assign bus.csr_num    = take_csr ? bus.csr_num_i    : '0;
  assign bus.csr_wmask  = take_csr ? bus.csr_wmask_i  : '0;
  assign bus.csr_wvalue = take_csr ? bus.csr_wvalue_i : '0;

  // Commit pulses; an interrupt reports its own code with a zero subcode.
  assign bus.exc_commit   = exc_take;
  assign bus.exc_ecode    = take_int ? ECODE_INT : (take_ex ? bus.wb_ecode : 6'd0);
  assign bus.exc_esubcode = take_ex ? bus.wb_esubcode : 9'd0;
  assign bus.exc_pc       = exc_take ? bus.wb_pc : 32'd0;
  assign bus.ertn_commit  = take_ertn;

  // Pipeline control; the commit cycle itself already flushes.
  assign bus.flush          = exc_take || take_ertn || (resetn && state_q == FLUSH);
  assign bus.redirect_valid = resetn && (state_q == REDIRECT);
  assign bus.redirect_pc    = bus.redirect_valid ? target_q : 32'd0;
  assign bus.ws_stall       = resetn && (state_q != IDLE);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (exc_take) begin
          state_d  = FLUSH;
          cnt_d    = CNT_LOAD;
          target_d = bus.csr_eentry;
        end else if (take_ertn) begin
          state_d  = FLUSH;
          cnt_d    = CNT_LOAD;
          target_d = bus.csr_era;
        end
      end
      FLUSH: begin
        // Counter stops at zero; leaving FLUSH is what ends the count.
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (bus.fetch_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Bench for excp_flush_ctrl: one DUT with the default FLUSH_CYCLES=2 and one
// with FLUSH_CYCLES=1 share the same stimulus. A timeline model (cycles since
// commit) predicts every output of both DUTs on every cycle; directed
// literal checks pin the model at the interesting points.
module tb_excp_flush_ctrl;

  localparam int         FC0      = 2;
  localparam int         FC1      = 1;
  localparam logic [5:0] ECODE_IN = 6'h00;

  typedef struct packed {
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        exc_commit;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_pc;
    logic        ertn_commit;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ws_stall;
  } out_t;

  localparam int OW = $bits(out_t);
  typedef logic [OW-1:0] val_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic        resetn;
  logic        wb_valid, wb_ex, wb_ertn;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        csr_we_req;
  logic [13:0] csr_num_i;
  logic [31:0] csr_wmask_i, csr_wvalue_i;
  logic        int_pending;
  logic [31:0] csr_eentry, csr_era;
  logic        fetch_ready;

  excp_flush_ctrl_if if0 ();
  excp_flush_ctrl_if if1 ();

  assign if0.wb_valid     = wb_valid;     assign if1.wb_valid     = wb_valid;
  assign if0.wb_ex        = wb_ex;        assign if1.wb_ex        = wb_ex;
  assign if0.wb_ertn      = wb_ertn;      assign if1.wb_ertn      = wb_ertn;
  assign if0.wb_ecode     = wb_ecode;     assign if1.wb_ecode     = wb_ecode;
  assign if0.wb_esubcode  = wb_esubcode;  assign if1.wb_esubcode  = wb_esubcode;
  assign if0.wb_pc        = wb_pc;        assign if1.wb_pc        = wb_pc;
  assign if0.csr_we_req   = csr_we_req;   assign if1.csr_we_req   = csr_we_req;
  assign if0.csr_num_i    = csr_num_i;    assign if1.csr_num_i    = csr_num_i;
  assign if0.csr_wmask_i  = csr_wmask_i;  assign if1.csr_wmask_i  = csr_wmask_i;
  assign if0.csr_wvalue_i = csr_wvalue_i; assign if1.csr_wvalue_i = csr_wvalue_i;
  assign if0.int_pending  = int_pending;  assign if1.int_pending  = int_pending;
  assign if0.csr_eentry   = csr_eentry;   assign if1.csr_eentry   = csr_eentry;
  assign if0.csr_era      = csr_era;      assign if1.csr_era      = csr_era;
  assign if0.fetch_ready  = fetch_ready;  assign if1.fetch_ready  = fetch_ready;

  excp_flush_ctrl #(.FLUSH_CYCLES(FC0), .ECODE_INT(ECODE_IN)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0)
  );
  excp_flush_ctrl #(.FLUSH_CYCLES(FC1), .ECODE_INT(ECODE_IN)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1)
  );

  out_t out0, out1;
  assign out0 = {if0.csr_we, if0.csr_num, if0.csr_wmask, if0.csr_wvalue,
                 if0.exc_commit, if0.exc_ecode, if0.exc_esubcode, if0.exc_pc,
                 if0.ertn_commit, if0.flush, if0.redirect_valid, if0.redirect_pc,
                 if0.ws_stall};
  assign out1 = {if1.csr_we, if1.csr_num, if1.csr_wmask, if1.csr_wvalue,
                 if1.exc_commit, if1.exc_ecode, if1.exc_esubcode, if1.exc_pc,
                 if1.ertn_commit, if1.flush, if1.redirect_valid, if1.redirect_pc,
                 if1.ws_stall};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input val_t got, input val_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d got=%h exp=%h", name, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = 0; wb_ex = 0; wb_ertn = 0; wb_ecode = '0; wb_esubcode = '0;
    wb_pc = '0; csr_we_req = 0; csr_num_i = '0; csr_wmask_i = '0;
    csr_wvalue_i = '0; int_pending = 0;
  endtask

  // Timeline model: a committed event occupies the controller for cycles
  // age = 0 .. FC (flush) and then age > FC (redirect) until IF accepts.
  bit          m_active [2];
  int          m_age    [2];
  logic [31:0] m_target [2];

  initial begin
    m_active = '{0, 0};
    m_age    = '{0, 0};
    m_target = '{32'd0, 32'd0};
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          out_t e;
          out_t g;
          bit   ti, te, tr, cw, rv;
          int   fc;
          e  = '0;
          fc = (k == 0) ? FC0 : FC1;
          g  = (k == 0) ? out0 : out1;
          if (!resetn) begin
            m_active[k] = 0;
            m_target[k] = 32'd0;
          end else if (!m_active[k]) begin
            ti = wb_valid && int_pending;
            te = wb_valid && wb_ex && !int_pending;
            tr = wb_valid && wb_ertn && !wb_ex && !int_pending;
            cw = wb_valid && csr_we_req && !wb_ex && !int_pending;
            e.exc_commit   = ti || te;
            e.exc_ecode    = ti ? ECODE_IN : (te ? wb_ecode : 6'd0);
            e.exc_esubcode = te ? wb_esubcode : 9'd0;
            e.exc_pc       = (ti || te) ? wb_pc : 32'd0;
            e.ertn_commit  = tr;
            e.csr_we       = cw;
            e.csr_num      = cw ? csr_num_i : 14'd0;
            e.csr_wmask    = cw ? csr_wmask_i : 32'd0;
            e.csr_wvalue   = cw ? csr_wvalue_i : 32'd0;
            e.flush        = ti || te || tr;
            if (ti || te || tr) begin
              m_active[k] = 1;
              m_age[k]    = 1;
              m_target[k] = (ti || te) ? csr_eentry : csr_era;
            end
          end else begin
            rv               = m_age[k] > fc;
            e.ws_stall       = 1'b1;
            e.flush          = !rv;
            e.redirect_valid = rv;
            e.redirect_pc    = rv ? m_target[k] : 32'd0;
            if (rv && fetch_ready) m_active[k] = 0;
            else m_age[k] = m_age[k] + 1;
          end
          check(k == 0 ? "model_dut0" : "model_dut1", val_t'(g), val_t'(e));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fl0, rv0, fl1, rv1;
    bit         seen;
    int         waited;

    // Reset, with an exception presented to show gating during reset.
    resetn = 0; fetch_ready = 1; csr_eentry = '0; csr_era = '0;
    clear_wb();
    step();
    chk_en = 1;
    wb_valid = 1; wb_ex = 1; csr_we_req = 1;
    #1;
    check("rst_exc_commit", val_t'(if0.exc_commit), val_t'(1'b0));
    check("rst_csr_we",     val_t'(if0.csr_we),     val_t'(1'b0));
    check("rst_flush",      val_t'(if0.flush),      val_t'(1'b0));
    step();
    clear_wb();
    resetn = 1;
    #1;
    check("idle_ws_stall", val_t'(if0.ws_stall),       val_t'(1'b0));
    check("idle_redirect", val_t'(if0.redirect_valid), val_t'(1'b0));
    step();

    // Exception commit, flush length and redirect target.
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0100;
    csr_eentry = 32'h1C00_8000;
    #1;
    check("ex_commit", val_t'(if0.exc_commit), val_t'(1'b1));
    check("ex_ecode",  val_t'(if0.exc_ecode),  val_t'(6'h0B));
    check("ex_pc",     val_t'(if0.exc_pc),     val_t'(32'h1C00_0100));
    fl0 = '0; rv0 = '0; fl1 = '0; rv1 = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        step();
        clear_wb();
        csr_eentry = 32'hDEAD_0000;
        #1;
      end
      fl0[i] = if0.flush; rv0[i] = if0.redirect_valid;
      fl1[i] = if1.flush; rv1[i] = if1.redirect_valid;
      if (i == 3) check("ex_redirect_pc", val_t'(if0.redirect_pc), val_t'(32'h1C00_8000));
    end
    check("ex_flush_fc2",    val_t'(fl0), val_t'(6'b000111));
    check("ex_redirect_fc2", val_t'(rv0), val_t'(6'b001000));
    check("ex_flush_fc1",    val_t'(fl1), val_t'(6'b000011));
    check("ex_redirect_fc1", val_t'(rv1), val_t'(6'b000100));

    // Priority: interrupt beats exception, ERTN and CSR write.
    step();
    csr_eentry = 32'h1C00_8000;
    wb_valid = 1; wb_ex = 1; wb_ertn = 1; int_pending = 1; csr_we_req = 1;
    wb_ecode = 6'h0B; csr_num_i = 14'h006;
    #1;
    check("pri_exc_commit",  val_t'(if0.exc_commit),  val_t'(1'b1));
    check("pri_ecode",       val_t'(if0.exc_ecode),   val_t'(6'h00));
    check("pri_ertn_commit", val_t'(if0.ertn_commit), val_t'(1'b0));
    check("pri_csr_we",      val_t'(if0.csr_we),      val_t'(1'b0));
    step();
    clear_wb();
    for (int i = 0; i < 6; i++) step();

    // ERTN together with a CSR write, then redirect back-pressure.
    wb_valid = 1; wb_ertn = 1; csr_we_req = 1; csr_num_i = 14'h006;
    csr_wmask_i = 32'hFFFF_FFFF; csr_wvalue_i = 32'h0000_1234;
    csr_era = 32'h1C00_0204; fetch_ready = 0;
    #1;
    check("ertn_csr_we",     val_t'(if0.csr_we),      val_t'(1'b1));
    check("ertn_commit",     val_t'(if0.ertn_commit), val_t'(1'b1));
    check("ertn_csr_num",    val_t'(if0.csr_num),     val_t'(14'h006));
    check("ertn_csr_wvalue", val_t'(if0.csr_wvalue),  val_t'(32'h0000_1234));
    check("ertn_no_exc",     val_t'(if0.exc_commit),  val_t'(1'b0));
    step();
    clear_wb();
    csr_era = 32'h0BAD_0000;
    waited = 0;
    while (!if0.redirect_valid && waited < 10) begin
      step();
      waited++;
    end
    check("ertn_redirect_reached", val_t'(if0.redirect_valid), val_t'(1'b1));
    check("ertn_redirect_pc",      val_t'(if0.redirect_pc),    val_t'(32'h1C00_0204));
    wb_valid = 1; csr_we_req = 1; csr_num_i = 14'h006;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_redirect_valid", val_t'(if0.redirect_valid), val_t'(1'b1));
      check("bp_redirect_pc",    val_t'(if0.redirect_pc),    val_t'(32'h1C00_0204));
      check("bp_ws_stall",       val_t'(if0.ws_stall),       val_t'(1'b1));
      check("bp_csr_we",         val_t'(if0.csr_we),         val_t'(1'b0));
    end
    clear_wb();
    fetch_ready = 1;
    step();
    check("bp_release_stall",    val_t'(if0.ws_stall),       val_t'(1'b0));
    check("bp_release_redirect", val_t'(if0.redirect_valid), val_t'(1'b0));

    // Reset in the middle of FLUSH abandons the redirect.
    step();
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0A; wb_pc = 32'h1C00_0300;
    step();
    clear_wb();
    resetn = 0;
    #1;
    check("mid_rst_flush_gated", val_t'(if0.flush), val_t'(1'b0));
    step();
    resetn = 1;
    #1;
    check("mid_rst_flush",    val_t'(if0.flush),          val_t'(1'b0));
    check("mid_rst_redirect", val_t'(if0.redirect_valid), val_t'(1'b0));
    check("mid_rst_stall",    val_t'(if0.ws_stall),       val_t'(1'b0));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | if0.redirect_valid | if1.redirect_valid;
    end
    check("mid_rst_no_redirect", val_t'(seen), val_t'(1'b0));

    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
